// File: rtl/ptw_refill_queue.sv
// Refill queue between the PTW writeback port and the L2 TLB array / L1 response.
// Optional perf counters are built when PTW_REFILL_PERF_EN is defined.
module ptw_refill_queue #(
    parameter int DEPTH   = 4,
    parameter int VADDR_W = 32,
    parameter int PTE_W   = 32,
    parameter int INFO_W  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               ptw_valid,
    output logic               ptw_ready,
    input  logic               ptw_exc,
    input  logic [INFO_W-1:0]  ptw_info,
    input  logic [PTE_W-1:0]   ptw_entry,
    input  logic [VADDR_W-1:0] ptw_waddr,
    input  logic [1:0]         ptw_wpn,
    output logic               tlb_we,
    input  logic               tlb_wready,
    output logic [1:0]         tlb_wpn,
    output logic [VADDR_W-13:0] tlb_vpn,
    output logic [PTE_W-1:0]   tlb_entry,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_exc,
    output logic [INFO_W-1:0]  resp_info,
    output logic [VADDR_W-1:0] resp_vaddr,
    output logic [PTE_W-1:0]   resp_entry
`ifdef PTW_REFILL_PERF_EN
    ,
    output logic [31:0]        perf_refill,
    output logic [31:0]        perf_fault,
    output logic [31:0]        perf_stall
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic               exc;
        logic [INFO_W-1:0]  info;
        logic [PTE_W-1:0]   entry;
        logic [VADDR_W-1:0] waddr;
        logic [1:0]         wpn;
    } slot_t;

    typedef enum logic {
        EMPTY,
        ISSUE
    } state_t;

    slot_t         mem [DEPTH];
    slot_t         head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_d;
    logic          arr_done;
    logic          rsp_done;
    state_t        state;
    state_t        state_d;
    logic          issue;
    logic          push;
    logic          pop;
    logic          arr_ok;
    logic          rsp_ok;

    assign head      = mem[rd_ptr];
    assign ptw_ready = rst & ~flush & (count != FULL);
    assign push      = ptw_valid & ptw_ready;

    assign tlb_wpn    = head.wpn;
    assign tlb_vpn    = head.waddr[VADDR_W-1:12];
    assign tlb_entry  = head.entry;
    assign resp_exc   = head.exc;
    assign resp_info  = head.info;
    assign resp_vaddr = head.waddr;
    assign resp_entry = head.entry;

    // Faults never touch the array, so they count as already written.
    always_comb begin
        issue      = rst & (state == ISSUE);
        tlb_we     = issue & ~arr_done & ~head.exc;
        resp_valid = issue & ~rsp_done;
        arr_ok     = arr_done | head.exc | (tlb_we & tlb_wready);
        rsp_ok     = rsp_done | (resp_valid & resp_ready);
        pop        = issue & arr_ok & rsp_ok;
    end

    always_comb begin
        count_d = count;
        if (push && !pop) begin
            count_d = count + CW'(1);
        end else if (pop && !push) begin
            count_d = count - CW'(1);
        end
        state_d = state;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            state_d = (count_d != '0) ? ISSUE : EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            arr_done <= 1'b0;
            rsp_done <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            arr_done <= 1'b0;
            rsp_done <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{exc: ptw_exc, info: ptw_info, entry: ptw_entry,
                                 waddr: ptw_waddr, wpn: ptw_wpn};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + AW'(1);
                arr_done <= 1'b0;
                rsp_done <= 1'b0;
            end else begin
                arr_done <= arr_done | (tlb_we & tlb_wready);
                rsp_done <= rsp_done | (resp_valid & resp_ready);
            end
            count <= count_d;
        end
    end

`ifdef PTW_REFILL_PERF_EN
    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_refill <= '0;
            perf_fault  <= '0;
            perf_stall  <= '0;
        end else begin
            if (pop && !head.exc) begin
                perf_refill <= perf_refill + 32'd1;
            end
            if (pop && head.exc) begin
                perf_fault <= perf_fault + 32'd1;
            end
            if (ptw_valid && !ptw_ready) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ptw_refill_queue.sv
// Randomized bench for ptw_refill_queue against a queue-based reference model.
// Perf counters are checked when PTW_REFILL_PERF_EN is defined.
module tb_ptw_refill_queue;

    localparam int DEPTH   = 4;
    localparam int VADDR_W = 32;
    localparam int PTE_W   = 32;
    localparam int INFO_W  = 4;

    typedef struct {
        bit                 exc;
        logic [INFO_W-1:0]  info;
        logic [PTE_W-1:0]   entry;
        logic [VADDR_W-1:0] waddr;
        logic [1:0]         wpn;
    } req_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               ptw_valid;
    logic               ptw_ready;
    logic               ptw_exc;
    logic [INFO_W-1:0]  ptw_info;
    logic [PTE_W-1:0]   ptw_entry;
    logic [VADDR_W-1:0] ptw_waddr;
    logic [1:0]         ptw_wpn;
    logic               tlb_we;
    logic               tlb_wready;
    logic [1:0]         tlb_wpn;
    logic [VADDR_W-13:0] tlb_vpn;
    logic [PTE_W-1:0]   tlb_entry;
    logic               resp_valid;
    logic               resp_ready;
    logic               resp_exc;
    logic [INFO_W-1:0]  resp_info;
    logic [VADDR_W-1:0] resp_vaddr;
    logic [PTE_W-1:0]   resp_entry;
`ifdef PTW_REFILL_PERF_EN
    logic [31:0]        perf_refill;
    logic [31:0]        perf_fault;
    logic [31:0]        perf_stall;
`endif

    ptw_refill_queue #(
        .DEPTH(DEPTH), .VADDR_W(VADDR_W), .PTE_W(PTE_W), .INFO_W(INFO_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ptw_valid(ptw_valid), .ptw_ready(ptw_ready), .ptw_exc(ptw_exc),
        .ptw_info(ptw_info), .ptw_entry(ptw_entry), .ptw_waddr(ptw_waddr),
        .ptw_wpn(ptw_wpn),
        .tlb_we(tlb_we), .tlb_wready(tlb_wready), .tlb_wpn(tlb_wpn),
        .tlb_vpn(tlb_vpn), .tlb_entry(tlb_entry),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_exc(resp_exc),
        .resp_info(resp_info), .resp_vaddr(resp_vaddr), .resp_entry(resp_entry)
`ifdef PTW_REFILL_PERF_EN
        ,
        .perf_refill(perf_refill), .perf_fault(perf_fault), .perf_stall(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    req_t q[$];
    bit   a_done   = 0;
    bit   r_done   = 0;
    bit   fresh    = 0;
    bit   last_acc = 0;
    int unsigned m_refill = 0;
    int unsigned m_fault  = 0;
    int unsigned m_stall  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Check this cycle's outputs, advance the model across the edge, return at negedge.
    task automatic tick();
        req_t h;
        bit   ne, erdy, ew, ev, aok, rok, pop;
        #1;
        ne   = (q.size() != 0);
        erdy = rst && !flush && (q.size() < DEPTH);
        if (ne) h = q[0];
        ew = rst && ne && !a_done && !h.exc;
        ev = rst && ne && !r_done;
        chk("ptw_ready", ptw_ready, erdy);
        chk("tlb_we", tlb_we, ew);
        chk("resp_valid", resp_valid, ev);
        if (rst && ne) begin
            chk("resp_exc", resp_exc, h.exc);
            chk("resp_info", resp_info, h.info);
            chk("resp_vaddr", resp_vaddr, h.waddr);
            chk("resp_entry", resp_entry, h.entry);
            chk("tlb_vpn", tlb_vpn, h.waddr >> 12);
            chk("tlb_entry", tlb_entry, h.entry);
            chk("tlb_wpn", tlb_wpn, h.wpn);
        end else if (rst && fresh) begin
            chk("reset_vaddr", resp_vaddr, 0);
            chk("reset_entry", resp_entry, 0);
            chk("reset_info", {resp_exc, resp_info}, 0);
        end
`ifdef PTW_REFILL_PERF_EN
        chk("perf_refill", perf_refill, m_refill);
        chk("perf_fault", perf_fault, m_fault);
        chk("perf_stall", perf_stall, m_stall);
`endif
        last_acc = ptw_valid && erdy;
        if (!rst) begin
            q.delete();
            a_done = 0; r_done = 0; fresh = 1;
            m_refill = 0; m_fault = 0; m_stall = 0;
        end else begin
            aok = a_done || h.exc || (ew && tlb_wready);
            rok = r_done || (ev && resp_ready);
            pop = ne && aok && rok;
            if (pop && !h.exc) m_refill++;
            if (pop && h.exc) m_fault++;
            if (ptw_valid && !erdy) m_stall++;
            if (flush) begin
                q.delete();
                a_done = 0; r_done = 0;
            end else begin
                if (pop) begin
                    void'(q.pop_front());
                    a_done = 0; r_done = 0;
                end else if (ne) begin
                    a_done = aok && !h.exc;
                    r_done = rok;
                end
                if (last_acc) begin
                    q.push_back('{exc: ptw_exc, info: ptw_info, entry: ptw_entry,
                                  waddr: ptw_waddr, wpn: ptw_wpn});
                    fresh = 0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_req();
        ptw_exc   = ($urandom_range(0, 3) == 0);
        ptw_info  = INFO_W'($urandom);
        ptw_entry = $urandom;
        ptw_waddr = $urandom;
        ptw_wpn   = 2'($urandom_range(0, 1));
    endtask

    task automatic push_one(input bit exc, input logic [3:0] info, input logic [31:0] va);
        int n = 0;
        ptw_valid = 1; ptw_exc = exc; ptw_info = info;
        ptw_waddr = va; ptw_entry = va ^ 32'h5a5a_0001; ptw_wpn = 2'b00;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 40);
        if (!last_acc) chk("push_timeout", 0, 1);
        ptw_valid = 0;
    endtask

    int pv, pw, pr;

    initial begin
        rst = 0; flush = 0; ptw_valid = 0; tlb_wready = 1; resp_ready = 1;
        rand_req();
        @(negedge clk);
        tick();
        tick();
        rst = 1;
        tick();
        // T1
        push_one(0, 4'd3, 32'h8040_3000);
        chk("t1_vpn", tlb_vpn, 20'h80403);
        repeat (2) tick();
        // T2
        push_one(1, 4'd5, 32'h1234_5000);
        repeat (2) tick();
        // T3
        tlb_wready = 0;
        push_one(0, 4'd7, 32'h0000_a000);
        repeat (3) tick();
        tlb_wready = 1;
        repeat (2) tick();
        // T4
        resp_ready = 0;
        for (int i = 1; i <= 4; i++) push_one(0, 4'(i), 32'(i) << 12);
        ptw_valid = 1; ptw_info = 4'd5; ptw_waddr = 32'h5000;
        repeat (3) begin
            tick();
            chk("t4_held", last_acc, 0);
        end
        resp_ready = 1;
        push_one(0, 4'd5, 32'h5000);
        repeat (6) tick();
        // T5
        tlb_wready = 0; resp_ready = 0;
        for (int i = 0; i < 3; i++) push_one(0, 4'(8 + i), 32'h9000 + (32'(i) << 12));
        flush = 1; ptw_valid = 1;
        tick();
        chk("t5_dropped", last_acc, 0);
        flush = 0; ptw_valid = 0;
        tick();
        tlb_wready = 1; resp_ready = 1;
        // T6
        push_one(0, 4'd1, 32'h7000);
        push_one(0, 4'd2, 32'h8000);
        rst = 0;
        tick();
        rst = 1;
        tick();
        push_one(0, 4'd4, 32'hc000);
        repeat (2) tick();
        // Randomized phases
        for (int ph = 0; ph < 15; ph++) begin
            pv = (ph == 0) ? 100 : $urandom_range(20, 100);
            pw = (ph == 0) ? 100 : $urandom_range(10, 100);
            pr = (ph == 0) ? 100 : $urandom_range(10, 100);
            for (int c = 0; c < 200; c++) begin
                if (!(ptw_valid && !last_acc)) begin
                    ptw_valid = ($urandom_range(0, 99) < pv);
                    rand_req();
                end
                tlb_wready = ($urandom_range(0, 99) < pw);
                resp_ready = ($urandom_range(0, 99) < pr);
                flush      = (ph != 0) && ($urandom_range(0, 99) < 2);
                rst        = !((ph != 0) && ($urandom_range(0, 999) < 5));
                tick();
            end
        end
        rst = 1; flush = 0; ptw_valid = 0;
        tlb_wready = 1; resp_ready = 1;
        repeat (8) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
